// File: rtl/video_timing_if.sv
// Pixel stream bus around the video timing tracker: raw HDMI-in stream in,
// delayed stream plus coordinates, strobes and measured geometry out.
interface video_timing_if #(
  parameter int XW = 11,
  parameter int YW = 11
);
  logic          hs_i, vs_i, de_i;
  logic [23:0]   data_i;
  logic          hs_o, vs_o, de_o;
  logic [23:0]   data_o;
  logic [XW-1:0] x_o, width_o;
  logic [YW-1:0] y_o, height_o;
  logic          sol_o, sof_o, locked_o, err_o;

  modport slave (
    input  hs_i, vs_i, de_i, data_i,
    output hs_o, vs_o, de_o, data_o, x_o, y_o, sol_o, sof_o,
           width_o, height_o, locked_o, err_o
  );

  modport master (
    output hs_i, vs_i, de_i, data_i,
    input  hs_o, vs_o, de_o, data_o, x_o, y_o, sol_o, sof_o,
           width_o, height_o, locked_o, err_o
  );
endinterface

// File: rtl/video_timing.sv
// Timing tracker: one-stage pixel passthrough with active x/y, line/frame
// strobes, measured frame geometry and a lock flag for downstream stages.
module video_timing #(
  parameter int XW          = 11,
  parameter int YW          = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  video_timing_if.slave vif
);
  localparam int VW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [XW-1:0] XMAX = '1;
  localparam logic [YW-1:0] YMAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] xcnt, cand;
  logic [YW-1:0] ycnt;
  logic [VW-1:0] vcnt;
  logic          bad, sof_pend;
  logic          vs_rise, de_fall, meas_first, line_viol, h_mis;
  logic          err_d, cand_we, geom_we, bad_set, bad_clr, vcnt_clr, vcnt_inc;

  // The delayed outputs double as the registered sync copies for edge detection.
  assign vs_rise    = vif.vs_i & ~vif.vs_o;
  assign de_fall    = ~vif.de_i & vif.de_o;
  assign meas_first = (state_q == MEASURE) && (ycnt == '0);
  assign h_mis      = vs_rise && (state_q == VERIFY || state_q == LOCKED) &&
                      (ycnt != vif.height_o);

  always_comb begin
    line_viol = 1'b0;
    if (de_fall && state_q != SEARCH)
      line_viol = (xcnt == XMAX) || (ycnt == YMAX) ||
                  (!meas_first && xcnt != ((state_q == MEASURE) ? cand : vif.width_o));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEARCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEARCH:  if (vs_rise) state_d = MEASURE;
      MEASURE: if (vs_rise && !bad && ycnt != '0) state_d = VERIFY;
      VERIFY: begin
        if (line_viol || h_mis)                            state_d = MEASURE;
        else if (vs_rise && vcnt == VW'(LOCK_FRAMES - 1))  state_d = LOCKED;
      end
      LOCKED:  if (line_viol || h_mis) state_d = MEASURE;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    err_d    = line_viol | h_mis;
    cand_we  = de_fall && meas_first;
    geom_we  = (state_q == MEASURE) && (state_d == VERIFY);
    bad_set  = line_viol;
    bad_clr  = vs_rise && (state_q == MEASURE);
    vcnt_clr = geom_we;
    vcnt_inc = vs_rise && (state_q == VERIFY) && (state_d == VERIFY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vif.hs_o     <= 1'b0;
      vif.vs_o     <= 1'b0;
      vif.de_o     <= 1'b0;
      vif.data_o   <= '0;
      vif.x_o      <= '0;
      vif.y_o      <= '0;
      vif.sol_o    <= 1'b0;
      vif.sof_o    <= 1'b0;
      vif.width_o  <= '0;
      vif.height_o <= '0;
      vif.locked_o <= 1'b0;
      vif.err_o    <= 1'b0;
      xcnt         <= '0;
      ycnt         <= '0;
      cand         <= '0;
      vcnt         <= '0;
      bad          <= 1'b0;
      sof_pend     <= 1'b0;
    end else begin
      vif.hs_o   <= vif.hs_i;
      vif.vs_o   <= vif.vs_i;
      vif.de_o   <= vif.de_i;
      vif.data_o <= vif.data_i;

      if (vif.de_i) xcnt <= (xcnt == XMAX) ? xcnt : xcnt + 1'b1;
      else          xcnt <= '0;

      // Frame boundary wins over a line end landing on the same cycle.
      if (vs_rise)                      ycnt <= '0;
      else if (de_fall && ycnt != YMAX) ycnt <= ycnt + 1'b1;

      vif.x_o   <= vif.de_i ? xcnt : '0;
      vif.y_o   <= (vif.de_i && !vs_rise) ? ycnt : '0;
      vif.sol_o <= vif.de_i & ~vif.de_o;
      vif.sof_o <= vif.de_i & (vs_rise | sof_pend);
      sof_pend  <= vif.de_i ? 1'b0 : (sof_pend | vs_rise);

      vif.err_o    <= err_d;
      vif.locked_o <= (state_d == LOCKED);

      if (cand_we) cand <= xcnt;
      if (geom_we) begin
        vif.width_o  <= cand;
        vif.height_o <= ycnt;
      end

      bad <= bad_set | (bad & ~bad_clr);

      if (vcnt_clr)      vcnt <= '0;
      else if (vcnt_inc) vcnt <= vcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_video_timing.sv
// Randomized-data bench for video_timing: a frame/line-level geometry model
// predicts every registered output, plus directed checks on key milestones.
module tb_video_timing;
  localparam int XW = 11, YW = 11, LF = 2;
  localparam int XMAX = (1 << XW) - 1;
  localparam int YMAX = (1 << YW) - 1;
  localparam int M_SEARCH = 0, M_MEASURE = 1, M_VERIFY = 2, M_LOCKED = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_if #(.XW(XW), .YW(YW)) vif ();

  video_timing #(.XW(XW), .YW(YW), .LOCK_FRAMES(LF)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .vif   (vif)
  );

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  // geometry model state
  int m_mode, m_cand, m_w, m_h, m_vc;
  bit m_bad, m_err;
  // stream bookkeeping
  bit p_vs, p_de, sof_pend;
  int plen, ycount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SEARCH; m_cand = 0; m_w = 0; m_h = 0; m_vc = 0; m_bad = 0; m_err = 0;
    p_vs = 0; p_de = 0; sof_pend = 0; plen = 0; ycount = 0;
  endtask

  task automatic close_frame(input int lines);
    case (m_mode)
      M_SEARCH: m_mode = M_MEASURE;
      M_MEASURE: begin
        if (m_bad || lines == 0) m_bad = 0;
        else begin
          m_w = m_cand; m_h = lines; m_vc = 0; m_mode = M_VERIFY;
        end
      end
      default: begin
        if (lines != m_h) begin
          m_err = 1; m_mode = M_MEASURE; m_bad = 0;
        end else if (m_mode == M_VERIFY) begin
          m_vc++;
          if (m_vc == LF) m_mode = M_LOCKED;
        end
      end
    endcase
  endtask

  task automatic end_line(input int len, input int y);
    bit viol;
    if (m_mode == M_SEARCH) return;
    viol = (len == XMAX) || (y == YMAX);
    if (m_mode == M_MEASURE && y == 0) m_cand = len;
    else viol = viol || (len != ((m_mode == M_MEASURE) ? m_cand : m_w));
    if (viol) begin
      m_err = 1; m_bad = 1; m_mode = M_MEASURE;
    end
  endtask

  // One pixel clock: drive, predict, clock, compare.
  task automatic step(input bit vs, input bit de);
    logic [23:0] d;
    bit hs, vr, df, esol, esof;
    int ex, ey;
    d = 24'($urandom);
    hs = 1'($urandom);
    vif.hs_i = hs; vif.vs_i = vs; vif.de_i = de; vif.data_i = d;
    vr = vs && !p_vs;
    df = !de && p_de;
    m_err = 0;
    if (vr) begin
      close_frame(ycount);
      ycount = 0;
      sof_pend = 1;
    end
    if (df) begin
      end_line(plen, ycount);
      if (ycount < YMAX) ycount++;
    end
    ex = 0; ey = 0; esol = 0; esof = 0;
    if (de) begin
      ex = plen; ey = ycount; esol = !p_de; esof = sof_pend;
      sof_pend = 0;
      if (plen < XMAX) plen++;
    end else plen = 0;
    p_vs = vs; p_de = de;
    @(posedge clk);
    #1;
    chk("data_o", 32'(vif.data_o), 32'(d));
    chk("de_o", 32'(vif.de_o), 32'(de));
    chk("vs_o", 32'(vif.vs_o), 32'(vs));
    chk("hs_o", 32'(vif.hs_o), 32'(hs));
    chk("sol_o", 32'(vif.sol_o), 32'(esol));
    chk("sof_o", 32'(vif.sof_o), 32'(esof));
    chk("err_o", 32'(vif.err_o), 32'(m_err));
    chk("locked_o", 32'(vif.locked_o), 32'(m_mode == M_LOCKED));
    chk("width_o", 32'(vif.width_o), 32'(m_w));
    chk("height_o", 32'(vif.height_o), 32'(m_h));
    if (de) begin
      chk("x_o", 32'(vif.x_o), 32'(ex));
      chk("y_o", 32'(vif.y_o), 32'(ey));
    end
    if (vif.err_o) err_seen++;
  endtask

  // vs pulse (unless coinc), then nl lines; line bad_line gets bad_w pixels.
  task automatic frame(input int nl, input int w, input int bad_line, input int bad_w,
                       input bit coinc);
    int len;
    if (!coinc) begin
      repeat ($urandom_range(1, 3)) step(0, 0);
      step(1, 0);
      step(1, 0);
      repeat ($urandom_range(2, 4)) step(0, 0);
    end else begin
      step(0, 0);
      step(0, 0);
    end
    for (int l = 0; l < nl; l++) begin
      len = (l == bad_line) ? bad_w : w;
      for (int p = 0; p < len; p++) begin
        step(coinc && l == 0 && p < 2, 1);
        if (coinc && l == 0 && p == 0) begin
          chk("coinc_x", 32'(vif.x_o), 32'd0);
          chk("coinc_y", 32'(vif.y_o), 32'd0);
          chk("coinc_sof", 32'(vif.sof_o), 32'd1);
          chk("coinc_sol", 32'(vif.sol_o), 32'd1);
        end
      end
      repeat ($urandom_range(2, 4)) step(0, 0);
    end
  endtask

  initial begin
    vif.hs_i = 0; vif.vs_i = 0; vif.de_i = 0; vif.data_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(vif.locked_o), 32'd0);
    chk("rst_width", 32'(vif.width_o), 32'd0);
    chk("rst_height", 32'(vif.height_o), 32'd0);
    chk("rst_de", 32'(vif.de_o), 32'd0);
    chk("rst_err", 32'(vif.err_o), 32'd0);
    rst_n = 1'b1;

    // acquire lock on a clean 8x4 stream
    frame(4, 8, -1, 0, 0);
    frame(4, 8, -1, 0, 0);
    chk("geom_w_f2", 32'(vif.width_o), 32'd8);
    chk("geom_h_f2", 32'(vif.height_o), 32'd4);
    frame(4, 8, -1, 0, 0);
    chk("unlocked_f3", 32'(vif.locked_o), 32'd0);
    frame(4, 8, -1, 0, 0);
    chk("locked_f4", 32'(vif.locked_o), 32'd1);
    frame(4, 8, -1, 0, 0);
    chk("no_err_clean", 32'(err_seen), 32'd0);

    // short line while locked, then relock
    frame(4, 8, 2, 7, 0);
    chk("short_line_err", 32'(err_seen), 32'd1);
    chk("short_line_unlock", 32'(vif.locked_o), 32'd0);
    frame(4, 8, -1, 0, 0);
    frame(4, 8, -1, 0, 0);
    frame(4, 8, -1, 0, 0);
    chk("relock_pending", 32'(vif.locked_o), 32'd0);
    frame(4, 8, -1, 0, 0);
    chk("relocked", 32'(vif.locked_o), 32'd1);
    chk("width_kept", 32'(vif.width_o), 32'd8);

    // height change while locked
    frame(5, 8, -1, 0, 0);
    frame(5, 8, -1, 0, 0);
    chk("height_err", 32'(err_seen), 32'd2);
    chk("height_unlock", 32'(vif.locked_o), 32'd0);
    frame(5, 8, -1, 0, 0);
    chk("height_new", 32'(vif.height_o), 32'd5);
    frame(5, 8, -1, 0, 0);
    frame(5, 8, -1, 0, 0);
    chk("locked_h5", 32'(vif.locked_o), 32'd1);

    // vs rise on the first pixel of a line
    frame(5, 8, -1, 0, 1);
    chk("coinc_locked", 32'(vif.locked_o), 32'd1);

    // asynchronous reset mid-line while locked
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    repeat (3) step(0, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_de", 32'(vif.de_o), 32'd0);
    chk("arst_data", 32'(vif.data_o), 32'd0);
    chk("arst_x", 32'(vif.x_o), 32'd0);
    chk("arst_width", 32'(vif.width_o), 32'd0);
    chk("arst_height", 32'(vif.height_o), 32'd0);
    chk("arst_locked", 32'(vif.locked_o), 32'd0);
    chk("arst_hs_vs", 32'({vif.hs_o, vif.vs_o, vif.sol_o, vif.sof_o, vif.err_o}), 32'd0);
    vif.de_i = 0; vif.vs_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame(5, 8, -1, 0, 0);
    frame(5, 8, -1, 0, 0);
    frame(5, 8, -1, 0, 0);
    chk("post_rst_unlocked", 32'(vif.locked_o), 32'd0);
    frame(5, 8, -1, 0, 0);
    chk("post_rst_locked", 32'(vif.locked_o), 32'd1);

    // height drop, then a line long enough to saturate the x counter
    frame(4, 8, -1, 0, 0);
    frame(1, XMAX + 2, -1, 0, 0);
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("sat_err_total", 32'(err_seen), 32'd4);
    chk("sat_unlocked", 32'(vif.locked_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
